// File: rtl/demux_1to4_dispatcher_pkg.sv
// demux_1to4_dispatcher_pkg: shared state encoding and channel index width
package demux_1to4_dispatcher_pkg;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;
    localparam int CH_W = 2;
endpackage

// File: rtl/demux_1to4_dispatcher_demux.sv
// demux_1to4_d: routes one word to the selected channel, all other channels read 0
import demux_1to4_dispatcher_pkg::*;
module demux_1to4_d #(
    parameter int width = 16
) (
    input  logic             en,
    input  logic [width-1:0] i,
    input  logic [CH_W-1:0]  sel,
    output logic [width-1:0] o0,
    output logic [width-1:0] o1,
    output logic [width-1:0] o2,
    output logic [width-1:0] o3
);
    // steer the word to exactly one output while enabled
    always_comb begin
        o0 = (en && sel == 2'd0) ? i : '0;
        o1 = (en && sel == 2'd1) ? i : '0;
        o2 = (en && sel == 2'd2) ? i : '0;
        o3 = (en && sel == 2'd3) ? i : '0;
    end
endmodule

// File: rtl/demux_1to4_dispatcher.sv
// demux_1to4_dispatcher: accepts input words and hands each to one of four channels with timeout
import demux_1to4_dispatcher_pkg::*;
module demux_1to4_dispatcher #(
    parameter int width   = 16,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    input  logic [CH_W-1:0]  in_dest,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [width-1:0] o0,
    output logic [width-1:0] o1,
    output logic [width-1:0] o2,
    output logic [width-1:0] o3,
    output logic             busy,
    output logic             drop
);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]  sel_q, sel_d;
    logic [width-1:0] hold_q, hold_d;
    logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mode_q, mode_d;
    logic             drop_q, drop_d;
    logic             sending;

    assign sending   = (state_q == ST_SEND) && !rst;
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = sending ? (4'b0001 << sel_q) : 4'b0000;
    assign busy      = (state_q == ST_SEND);
    assign drop      = drop_q;

    // capture in IDLE; in SEND finish on ready, abandon on timeout, else keep counting
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        sel_d      = sel_q;
        hold_d     = hold_q;
        wait_cnt_d = wait_cnt_q;
        mode_d     = mode_q;
        drop_d     = 1'b0;
        if (state_q == ST_IDLE) begin
            if (in_valid) begin
                hold_d     = in_data;
                sel_d      = mode ? in_dest : rr_ptr_q;
                mode_d     = mode;
                wait_cnt_d = '0;
                state_d    = ST_SEND;
            end
        end else if (out_ready[sel_q]) begin
            state_d  = ST_IDLE;
            rr_ptr_d = mode_q ? rr_ptr_q : sel_q + 2'd1;
        end else if (TIMEOUT != 0 && wait_cnt_q == TO_LAST) begin
            state_d  = ST_IDLE;
            drop_d   = 1'b1;
            rr_ptr_d = mode_q ? rr_ptr_q : sel_q + 2'd1;
        end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            sel_q      <= '0;
            hold_q     <= '0;
            wait_cnt_q <= '0;
            mode_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_q      <= sel_d;
            hold_q     <= hold_d;
            wait_cnt_q <= wait_cnt_d;
            mode_q     <= mode_d;
            drop_q     <= drop_d;
        end
    end

    demux_1to4_d #(.width(width)) u_demux (
        .en  (sending),
        .i   (hold_q),
        .sel (sel_q),
        .o0  (o0),
        .o1  (o1),
        .o2  (o2),
        .o3  (o3)
    );
endmodule
